// File: rtl/wave_meter_if.sv
// Signal bundle between a square-wave source and the wave_meter measurement block.
// The master drives the wave and the slave (the meter) returns the measurement results.
interface wave_meter_if #(
   parameter int CNT_W = 8
);
   logic             in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high;
   logic             valid;
   logic             stall;
   logic [7:0]       nmeas;

   modport master (
      output in,
      input  period,
      input  high,
      input  valid,
      input  stall,
      input  nmeas
   );

   modport slave (
      input  in,
      output period,
      output high,
      output valid,
      output stall,
      output nmeas
   );
endinterface

// File: rtl/wave_meter.sv
// Measures period and high time of a clk-synchronous square wave, with a stall timeout.
//
// state | meaning
// IDLE  | waiting for the first rising edge after reset
// MEAS  | counting between rising edges; a measurement is reported on each edge
// STALL | no rising edge for TIMEOUT clocks; the next edge restarts counting
module wave_meter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         rst,
   wave_meter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEAS  = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic             in_d_q, in_d_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             stall_q, stall_d;
   logic [7:0]       nmeas_q, nmeas_d;
   logic             edge_w;

   // in_d resets to 1 so a wave already high at reset release is not taken as an edge
   assign edge_w = bus.in & ~in_d_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hcnt_d   = hcnt_q;
      in_d_d   = bus.in;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      stall_d  = stall_q;
      nmeas_d  = nmeas_q;

      case (state_q)
         IDLE: begin
            if (edge_w) begin
               state_d = MEAS;
               cnt_d   = ONE_C;
               hcnt_d  = ONE_C;
            end
         end
         MEAS: begin
            // an edge landing on the timeout cycle still counts as a measurement
            if (edge_w) begin
               period_d = cnt_q;
               high_d   = hcnt_q;
               valid_d  = 1'b1;
               nmeas_d  = nmeas_q + 8'd1;
               cnt_d    = ONE_C;
               hcnt_d   = ONE_C;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d = STALL;
               stall_d = 1'b1;
            end else begin
               cnt_d  = cnt_q + ONE_C;
               hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, bus.in};
            end
         end
         STALL: begin
            if (edge_w) begin
               state_d = MEAS;
               stall_d = 1'b0;
               cnt_d   = ONE_C;
               hcnt_d  = ONE_C;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         in_d_q   <= 1'b1;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
         nmeas_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         in_d_q   <= in_d_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
         nmeas_q  <= nmeas_d;
      end
   end

   assign bus.period = period_q;
   assign bus.high   = high_q;
   assign bus.valid  = valid_q;
   assign bus.stall  = stall_q;
   assign bus.nmeas  = nmeas_q;

endmodule

// File: tb/tb_wave_meter.sv
// Randomised bench for wave_meter: an edge-timestamp model predicts measurements into
// queues, and a monitor compares them against the DUT after every clock.
module tb_wave_meter;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 20;

   logic clk = 1'b0;
   logic rst;

   wave_meter_if #(.CNT_W(CNT_W)) bus ();

   wave_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      bit s;
      bit z;
   } cyc_t;

   typedef struct {
      int p;
      int h;
      int n;
   } meas_t;

   cyc_t  cyc_q[$];
   meas_t meas_q[$];
   int    checks = 0;
   int    errors = 0;

   // reference model: sample history plus the time of the last rising edge
   int now   = 0;
   bit prev  = 1'b1;
   bit armed = 1'b0;
   int last  = 0;
   int nm    = 0;
   bit wave[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, now, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit v);
      cyc_t c;
      @(negedge clk);
      rst    = r;
      bus.in = v;
      c.v = 1'b0;
      c.s = 1'b0;
      c.z = 1'b0;
      wave.push_back(v);
      if (r) begin
         prev  = 1'b1;
         armed = 1'b0;
         nm    = 0;
         c.z   = 1'b1;
      end else begin
         if (v && !prev) begin
            if (armed && (now - last) <= TIMEOUT) begin
               meas_t m;
               m.p = now - last;
               m.h = 0;
               for (int i = last; i < now; i++) m.h += int'(wave[i]);
               nm  = (nm + 1) % 256;
               m.n = nm;
               meas_q.push_back(m);
               c.v = 1'b1;
            end
            armed = 1'b1;
            last  = now;
         end
         prev = v;
         c.s  = armed && ((now - last) >= TIMEOUT);
      end
      cyc_q.push_back(c);
      now++;
   endtask

   task automatic pat(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi; i++) step(1'b0, 1'b1);
         for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
      end
   endtask

   // monitor
   initial begin
      cyc_t  c;
      meas_t m;
      forever begin
         @(posedge clk);
         #1;
         if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("valid", int'(bus.valid), int'(c.v));
            chk("stall", int'(bus.stall), int'(c.s));
            if (c.z) begin
               chk("rst_period", int'(bus.period), 0);
               chk("rst_high", int'(bus.high), 0);
               chk("rst_nmeas", int'(bus.nmeas), 0);
            end
            if (bus.valid) begin
               if (meas_q.size() == 0) begin
                  chk("unexpected_valid", 1, 0);
               end else begin
                  m = meas_q.pop_front();
                  chk("period", int'(bus.period), m.p);
                  chk("high", int'(bus.high), m.h);
                  chk("nmeas", int'(bus.nmeas), m.n);
               end
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      bus.in = 1'b0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      pat(2, 2, 6);
      pat(1, 1, 8);
      pat(3, 5, 5);
      pat(6, 2, 5);

      // single edge then held low: stall, then restart
      step(1'b0, 1'b1);
      repeat (30) step(1'b0, 1'b0);
      pat(1, 3, 3);

      pat(1, 19, 3);
      pat(1, 20, 3);
      pat(2, 2, 2);

      // reset mid-period with the wave held high
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1);
      pat(2, 2, 4);

      repeat (300) begin
         if ($urandom_range(0, 40) == 0) step(1'b1, 1'($urandom_range(0, 1)));
         pat(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), 1);
      end
      repeat (40) pat(int'($urandom_range(1, 12)), int'($urandom_range(1, 25)), 1);
      pat(1, 1, 4);
      repeat (4) step(1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      chk("leftover_expected", meas_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
